// File: rtl/apu_pkg.sv
// Shared APU package: frame-sequencer step positions, $4017 reset-delay
// constants and the sequencer mode type.
package apu_pkg;

  // Pre-increment CPU-cycle counts at which frame steps are decoded.
  localparam logic [15:0] STEP_Q1   = 16'd7457;
  localparam logic [15:0] STEP_H1   = 16'd14913;
  localparam logic [15:0] STEP_Q3   = 16'd22371;
  localparam logic [15:0] STEP_IRQ0 = 16'd29828;
  localparam logic [15:0] STEP_4END = 16'd29829;
  localparam logic [15:0] STEP_5END = 16'd37281;

  // Sequencer reset delay after a $4017 write, chosen by CPU-cycle parity.
  localparam logic [2:0] RST_DELAY_ODD  = 3'd3;
  localparam logic [2:0] RST_DELAY_EVEN = 3'd4;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } seq_mode_e;

  // Last count of a frame; the counter wraps to 0 after it.
  function automatic logic [15:0] frame_end(input seq_mode_e m);
    return (m == MODE_5STEP) ? STEP_5END : STEP_4END;
  endfunction

endpackage

// File: rtl/apu_frame_counter_gen2.sv
// APU frame sequencer ($4017). Produces the quarter-frame (e_pulse) and
// half-frame (l_pulse) strobes for the channels, plus the sticky frame IRQ.
// Ports:
//   clk, rst       - system clock, async active-high reset
//   apu_clk        - 1-clk strobe per CPU cycle
//   wren, from_cpu - $4017 write strobe and data (bit7 mode, bit6 inhibit)
//   irq_clear      - 1-clk strobe on a $4015 read
//   e_pulse        - quarter-frame strobe, 1 clk wide
//   l_pulse        - half-frame strobe, 1 clk wide
//   frame_irq      - sticky frame interrupt flag
//   mode_out       - current mode bit (1 = 5-step)
module apu_frame_counter_gen2
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_clk,
  input  logic       wren,
  input  logic [7:0] from_cpu,
  input  logic       irq_clear,
  output logic       e_pulse,
  output logic       l_pulse,
  output logic       frame_irq,
  output logic       mode_out
);

  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic        parity_q, parity_d;
  seq_mode_e   mode_q, mode_d;
  logic        inhibit_q, inhibit_d;
  logic        rst_pending_q, rst_pending_d;
  logic [2:0]  rst_delay_q, rst_delay_d;
  logic        wrapped_q, wrapped_d;
  logic        e_pulse_q, e_pulse_d;
  logic        l_pulse_q, l_pulse_d;
  logic        frame_irq_q, frame_irq_d;
  logic        irq_set;
  logic        reset_fire;

  // Only the mode and inhibit bits of $4017 are meaningful here.
  logic unused_cpu_bits;
  assign unused_cpu_bits = ^from_cpu[5:0];

  always_comb begin
    cyc_cnt_d     = cyc_cnt_q;
    parity_d      = parity_q;
    mode_d        = mode_q;
    inhibit_d     = inhibit_q;
    rst_pending_d = rst_pending_q;
    rst_delay_d   = rst_delay_q;
    wrapped_d     = wrapped_q;
    e_pulse_d     = 1'b0;
    l_pulse_d     = 1'b0;
    frame_irq_d   = frame_irq_q;
    irq_set       = 1'b0;
    reset_fire    = 1'b0;

    if (apu_clk) begin
      parity_d = ~parity_q;
      if (rst_pending_q) begin
        rst_delay_d = rst_delay_q - 3'd1;
        reset_fire  = (rst_delay_q == 3'd1);
      end

      if (reset_fire) begin
        // Delayed sequencer reset replaces the normal step decode this cycle.
        cyc_cnt_d     = '0;
        rst_pending_d = 1'b0;
        wrapped_d     = 1'b0;
        e_pulse_d     = (mode_q == MODE_5STEP);
        l_pulse_d     = (mode_q == MODE_5STEP);
      end else begin
        wrapped_d = (cyc_cnt_q == frame_end(mode_q));
        cyc_cnt_d = wrapped_d ? '0 : cyc_cnt_q + 16'd1;
        if (cyc_cnt_q == STEP_Q1 || cyc_cnt_q == STEP_Q3) begin
          e_pulse_d = 1'b1;
        end
        if (cyc_cnt_q == STEP_H1 || wrapped_d) begin
          e_pulse_d = 1'b1;
          l_pulse_d = 1'b1;
        end
        // The IRQ is raised on three consecutive cycles around the wrap.
        if (mode_q == MODE_4STEP &&
            (cyc_cnt_q == STEP_IRQ0 || cyc_cnt_q == STEP_4END ||
             (cyc_cnt_q == '0 && wrapped_q))) begin
          irq_set = 1'b1;
        end
      end
    end

    // A write reloads the delay after any decrement above, so the first
    // decrement of a fresh load happens on the following apu_clk.
    if (wren) begin
      mode_d        = seq_mode_e'(from_cpu[7]);
      inhibit_d     = from_cpu[6];
      rst_delay_d   = parity_q ? RST_DELAY_ODD : RST_DELAY_EVEN;
      rst_pending_d = 1'b1;
    end

    if (irq_set && !inhibit_d) begin
      frame_irq_d = 1'b1;
    end else if (irq_clear || (wren && from_cpu[6])) begin
      frame_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q     <= '0;
      parity_q      <= 1'b0;
      mode_q        <= MODE_4STEP;
      inhibit_q     <= 1'b0;
      rst_pending_q <= 1'b0;
      rst_delay_q   <= '0;
      wrapped_q     <= 1'b0;
      e_pulse_q     <= 1'b0;
      l_pulse_q     <= 1'b0;
      frame_irq_q   <= 1'b0;
    end else begin
      cyc_cnt_q     <= cyc_cnt_d;
      parity_q      <= parity_d;
      mode_q        <= mode_d;
      inhibit_q     <= inhibit_d;
      rst_pending_q <= rst_pending_d;
      rst_delay_q   <= rst_delay_d;
      wrapped_q     <= wrapped_d;
      e_pulse_q     <= e_pulse_d;
      l_pulse_q     <= l_pulse_d;
      frame_irq_q   <= frame_irq_d;
    end
  end

  assign e_pulse   = e_pulse_q;
  assign l_pulse   = l_pulse_q;
  assign frame_irq = frame_irq_q;
  assign mode_out  = (mode_q == MODE_5STEP);

endmodule

// File: doc/apu_frame_counter_gen2.md
# apu_frame_counter_gen2

APU frame sequencer that generates the quarter-frame (`e_pulse`) and half-frame (`l_pulse`) strobes consumed by the pulse, triangle and noise channels, and the frame IRQ. It implements the $4017 register (4-step/5-step mode, IRQ inhibit), including the delayed sequencer reset after a write. It sits in the APU top beside the channel instances and fans its strobes out to every channel's envelope, length-counter and sweep logic.

## Interface
- No parameters; step constants come from the shared package.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `apu_clk` in 1: 1-clk strobe once per CPU cycle; the same strobe the channels receive.
- `wren` in 1: 1-clk write strobe for $4017.
- `from_cpu` in 8: write data; bit 7 = mode (1 = 5-step), bit 6 = IRQ inhibit.
- `irq_clear` in 1: 1-clk strobe on a CPU read of $4015.
- `e_pulse` out 1: quarter-frame strobe, 1 clk wide.
- `l_pulse` out 1: half-frame strobe, 1 clk wide.
- `frame_irq` out 1: sticky frame interrupt flag.
- `mode_out` out 1: current mode bit, for debug/status.

## Operation
- `cyc_cnt` is 16 bits and counts CPU cycles. It increments on every `apu_clk`.
- Step events are decoded from the pre-increment `cyc_cnt` value on an `apu_clk`.
- 4-step mode (period 29830, wraps to 0 after 29829):
  - Q at 7457 and 22371.
  - Q+H at 14913 and 29829.
  - IRQ set at 29828, 29829, and at 0 when that 0 was reached by a wrap. A `wrapped` flag tracks this and clears on the next `apu_clk`.
- 5-step mode (period 37282, wraps to 0 after 37281):
  - Q at 7457 and 22371.
  - Q+H at 14913 and 37281.
  - Nothing at 29828/29829; never sets IRQ.
- Q asserts `e_pulse`; H asserts `l_pulse`. Both are 1-clk pulses.
- A `parity` flop toggles on each `apu_clk`.
- $4017 write:
  - `mode` and `inhibit` latch immediately.
  - `inhibit`=1 clears `frame_irq` on the same edge.
  - The 3-bit `rst_delay` loads 3 if `parity`=1, else 4, and `rst_pending` sets.
- Each `apu_clk` with `rst_pending` set decrements `rst_delay`. When `rst_delay` reaches 0:
  - `cyc_cnt` is forced to 0 and `rst_pending` clears; no normal step event fires that cycle.
  - If `mode`=1, `e_pulse` and `l_pulse` both pulse.
- A write while `rst_pending` is set reloads the delay; the latest data wins.
- `irq_clear` clears `frame_irq`. If an IRQ set occurs on the same clk, the set wins.
- While `inhibit`=1, IRQ sets are suppressed.
- `mode_out` equals the `mode` register.

## Timing
- Async reset values: `cyc_cnt`=0, `parity`=0, `mode`=0, `inhibit`=0, `rst_pending`=0, `wrapped`=0.
- Outputs on reset: `e_pulse`=0, `l_pulse`=0, `frame_irq`=0, `mode_out`=0.
- Step strobes are registered: asserted the clk after the `apu_clk` strobe that decodes the step, for exactly 1 clk. Channels therefore see them aligned one clk after `apu_clk`.
- `frame_irq` rises 1 clk after the decoding `apu_clk`. It falls 1 clk after `irq_clear`, or after a write with bit 6=1.
- Write-to-reset latency is 3 or 4 `apu_clk` strobes, per parity at the write clk.
- Simultaneous `wren` and `apu_clk` on one clk: the step decode uses the old `cyc_cnt`. The delay loads; its first decrement happens on the next `apu_clk`.
- `rst` asserted mid-frame returns the block to the reset state immediately; there is no pulse on deassertion.

## Structure
- Shared package `apu_pkg`:
  - Step localparams: `STEP_Q1`=7457, `STEP_H1`=14913, `STEP_Q3`=22371, `STEP_IRQ0`=29828, `STEP_4END`=29829, `STEP_5END`=37281.
  - Delay constants 3/4.
- No sub-module. The step decode is a single combinational `always` block in the same file.

## Test plan
- Reset, `mode`=0, free-run 29830 `apu_clk` -> `e_pulse` at counts 7457/14913/22371/29829; `l_pulse` at 14913/29829; `frame_irq`=1 from 29828.
- After `frame_irq` sets, `irq_clear` at count 29828 -> flag re-sets at 29829. Clear again at count 29829 -> flag re-sets at wrapped 0.
- Write 0x80 with `parity`=1 -> exactly 3 `apu_clk` later `cyc_cnt`=0 with simultaneous `e_pulse` and `l_pulse`; next steps at 7457/14913/22371/37281; no IRQ over 2 frames.
- Write 0x40 while `frame_irq`=1 -> flag clears next clk; no set at 29828/29829; `e_pulse` timing unchanged.
- Write 0x00 with `parity`=0, then a second write 0x80 two `apu_clk` later -> reset occurs 4 `apu_clk` after the second write, with Q+H pulses.
- Assert `rst` at count 20000 -> all outputs 0 immediately; first `e_pulse` after release at count 7457.
